row_max_locator: RTL and testbench

ROW_MAX_LOCATOR -- requirements
Module: row_max_locator

---
 rtl/row_max_locator.sv | 131 +++++++++++++
 tb/tb_row_max_locator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/row_max_locator.sv
// Row maximum locator: scans N_ROW rows of N_COL scores and reports each row's max and the mask of columns holding it.
// Optional macro ROW_THRESH_EN zeroes any row result whose max falls below MIN_SCORE.
module row_max_locator #(
    parameter int         N_COL     = 13,
    parameter int         N_ROW     = 4,
    parameter logic [6:0] MIN_SCORE = 7'd8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cell_valid,
    input  logic [6:0]       cell_data,
    output logic             cell_ready,
    output logic [6:0]       max1,
    output logic [6:0]       max2,
    output logic [6:0]       max3,
    output logic [6:0]       max4,
    output logic [N_COL-1:0] loc1,
    output logic [N_COL-1:0] loc2,
    output logic [N_COL-1:0] loc3,
    output logic [N_COL-1:0] loc4,
    output logic             out_valid,
    output logic             busy
);

    localparam int COL_W = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int ROW_W = (N_ROW > 1) ? $clog2(N_ROW) : 1;

`ifdef ROW_THRESH_EN
    localparam bit ThreshOn = 1'b1;
`else
    localparam bit ThreshOn = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [6:0]       runMax_q, runMax_d;
    logic [N_COL-1:0] runLoc_q, runLoc_d;
    logic [6:0]       max_q [4];
    logic [N_COL-1:0] loc_q [4];
    logic [N_COL-1:0] colBit;
    logic [6:0]       rowMax;
    logic [N_COL-1:0] rowLoc;
    logic             lastCol, lastRow;

    assign colBit  = N_COL'(1) << col_q;
    assign lastCol = (col_q == COL_W'(N_COL - 1));
    assign lastRow = (row_q == ROW_W'(N_ROW - 1));

    // Running max/loc including the current cell; column 0 always restarts the row.
    always_comb begin
        runMax_d = runMax_q;
        runLoc_d = runLoc_q;
        if (col_q == '0 || cell_data > runMax_q) begin
            runMax_d = cell_data;
            runLoc_d = colBit;
        end else if (cell_data == runMax_q) begin
            runLoc_d = runLoc_q | colBit;
        end
        rowMax = runMax_d;
        rowLoc = runLoc_d;
        if (ThreshOn && runMax_d < MIN_SCORE) begin
            rowMax = '0;
            rowLoc = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            runMax_q <= '0;
            runLoc_q <= '0;
            for (int i = 0; i < 4; i++) begin
                max_q[i] <= '0;
                loc_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q  <= SCAN;
                        col_q    <= '0;
                        row_q    <= '0;
                        runMax_q <= '0;
                        runLoc_q <= '0;
                        for (int i = 0; i < 4; i++) begin
                            max_q[i] <= '0;
                            loc_q[i] <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (cell_valid) begin
                        runMax_q <= runMax_d;
                        runLoc_q <= runLoc_d;
                        if (lastCol) begin
                            col_q        <= '0;
                            row_q        <= row_q + 1'b1;
                            max_q[row_q] <= rowMax;
                            loc_q[row_q] <= rowLoc;
                            if (lastRow) begin
                                state_q <= DONE;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cell_ready = (state_q == SCAN);
    assign busy       = (state_q == SCAN);
    assign out_valid  = (state_q == DONE);
    assign max1       = max_q[0];
    assign max2       = max_q[1];
    assign max3       = max_q[2];
    assign max4       = max_q[3];
    assign loc1       = loc_q[0];
    assign loc2       = loc_q[1];
    assign loc3       = loc_q[2];
    assign loc4       = loc_q[3];

endmodule

// File: tb/tb_row_max_locator.sv
// Self-checking bench for row_max_locator: directed and random passes checked against a per-row max/mask model.
// Honours ROW_THRESH_EN in the model when the macro is defined.
module tb_row_max_locator;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cell_valid;
    logic [6:0]  cell_data;
    logic        cell_ready;
    logic [6:0]  max1, max2, max3, max4;
    logic [12:0] loc1, loc2, loc3, loc4;
    logic        out_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [6:0] cells [52];
    int         expMax [4];
    int         expLoc [4];

    row_max_locator dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cell_valid (cell_valid),
        .cell_data  (cell_data),
        .cell_ready (cell_ready),
        .max1       (max1),
        .max2       (max2),
        .max3       (max3),
        .max4       (max4),
        .loc1       (loc1),
        .loc2       (loc2),
        .loc3       (loc3),
        .loc4       (loc4),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: each row's max is the largest score; the mask marks every column equal to it.
    task automatic computeExpected();
        for (int r = 0; r < 4; r++) begin
            int m = 0;
            int loc = 0;
            for (int c = 0; c < 13; c++)
                if (int'(cells[r*13+c]) > m) m = int'(cells[r*13+c]);
            for (int c = 0; c < 13; c++)
                if (int'(cells[r*13+c]) == m) loc = loc | (1 << c);
`ifdef ROW_THRESH_EN
            if (m < 8) begin
                m = 0;
                loc = 0;
            end
`endif
            expMax[r] = m;
            expLoc[r] = loc;
        end
    endtask

    task automatic checkResults(input string tag);
        computeExpected();
        checkOutput({tag, ".max1"}, 32'(max1), expMax[0]);
        checkOutput({tag, ".max2"}, 32'(max2), expMax[1]);
        checkOutput({tag, ".max3"}, 32'(max3), expMax[2]);
        checkOutput({tag, ".max4"}, 32'(max4), expMax[3]);
        checkOutput({tag, ".loc1"}, 32'(loc1), expLoc[0]);
        checkOutput({tag, ".loc2"}, 32'(loc2), expLoc[1]);
        checkOutput({tag, ".loc3"}, 32'(loc3), expLoc[2]);
        checkOutput({tag, ".loc4"}, 32'(loc4), expLoc[3]);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, ".outValid"}, 32'(out_valid), 0);
        checkOutput({tag, ".max1"}, 32'(max1), 0);
        checkOutput({tag, ".max4"}, 32'(max4), 0);
        checkOutput({tag, ".loc1"}, 32'(loc1), 0);
        checkOutput({tag, ".loc4"}, 32'(loc4), 0);
    endtask

    task automatic checkResetState(input string tag);
        checkCleared(tag);
        checkOutput({tag, ".cellReady"}, 32'(cell_ready), 0);
        checkOutput({tag, ".busy"}, 32'(busy), 0);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds cells[lo..hi-1]; with stall set, cell_valid alternates 1/0 every cycle.
    task automatic applyStimulus(input int lo, input int hi, input bit stall);
        int idx = lo;
        int guard = 0;
        bit phase = 1'b1;
        bit acc;
        while (idx < hi && guard < 400) begin
            cell_valid = stall ? phase : 1'b1;
            phase = !phase;
            cell_data = cells[idx];
            acc = cell_valid && cell_ready;
            if (acc && idx == 51) checkOutput("preLastOutValid", 32'(out_valid), 0);
            @(negedge clk);
            guard++;
            if (acc) idx++;
        end
        cell_valid = 1'b0;
        cell_data = '0;
        checkOutput("feedBudget", idx, hi);
    endtask

    task automatic runPass(input string tag, input bit stall);
        pulseStart();
        checkOutput({tag, ".busyAfterStart"}, 32'(busy), 1);
        applyStimulus(0, 52, stall);
        checkOutput({tag, ".outValid"}, 32'(out_valid), 1);
        checkOutput({tag, ".busyDone"}, 32'(busy), 0);
        checkResults(tag);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cell_valid = 1'b0;
        cell_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkResetState("reset");

        // Row 0 ascending, row 1 with a twin peak of 9, rows 2-3 random.
        for (int c = 0; c < 13; c++) cells[c] = 7'(c);
        for (int c = 0; c < 13; c++) cells[13+c] = (c == 3 || c == 6) ? 7'd9 : 7'd2;
        for (int i = 26; i < 52; i++) cells[i] = 7'($urandom_range(0, 127));
        pulseStart();
        checkOutput("passA.busy", 32'(busy), 1);
        checkOutput("passA.cellReady", 32'(cell_ready), 1);
        checkCleared("passA.early");
        applyStimulus(0, 52, 1'b0);
        checkOutput("passA.outValid", 32'(out_valid), 1);
        checkResults("passA");
        checkOutput("ascend.max1", 32'(max1), 12);
        checkOutput("ascend.loc1", 32'(loc1), 32'h1000);
        checkOutput("twin.max2", 32'(max2), 9);
        checkOutput("twin.loc2", 32'(loc2), 32'h0048);

        // DONE ignores offered cells and holds everything.
        cell_valid = 1'b1;
        cell_data = 7'd127;
        repeat (3) @(negedge clk);
        checkOutput("done.cellReady", 32'(cell_ready), 0);
        checkOutput("done.busy", 32'(busy), 0);
        checkOutput("done.outValid", 32'(out_valid), 1);
        checkResults("doneHold");
        cell_valid = 1'b0;

        // Start from DONE clears outputs on the same edge.
        for (int i = 0; i < 52; i++) cells[i] = 7'd5;
        pulseStart();
        checkCleared("restartDone");
        checkOutput("restartDone.busy", 32'(busy), 1);
        applyStimulus(0, 52, 1'b0);
        checkOutput("allFive.outValid", 32'(out_valid), 1);
        checkResults("allFive");

        // Tie-heavy data, then the same data with a stalled feed.
        for (int i = 0; i < 52; i++) cells[i] = 7'($urandom_range(0, 3));
        runPass("ties", 1'b0);
        runPass("tiesStalled", 1'b1);
        for (int i = 0; i < 52; i++) cells[i] = 7'($urandom_range(0, 127));
        runPass("randStalled", 1'b1);

        // Start mid-scan must not restart the pass.
        for (int i = 0; i < 52; i++) cells[i] = 7'($urandom_range(0, 127));
        pulseStart();
        applyStimulus(0, 10, 1'b0);
        pulseStart();
        checkOutput("midStart.busy", 32'(busy), 1);
        applyStimulus(10, 52, 1'b0);
        checkOutput("midStart.outValid", 32'(out_valid), 1);
        checkResults("midStart");

        // Reset after 20 cells discards the partial pass.
        for (int i = 0; i < 52; i++) cells[i] = 7'd127;
        pulseStart();
        applyStimulus(0, 20, 1'b0);
        rst = 1'b1;
        cell_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cell_valid = 1'b0;
        start = 1'b0;
        checkResetState("midReset");
        for (int i = 0; i < 52; i++) cells[i] = 7'($urandom_range(0, 20));
        runPass("afterReset", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
